top_cmd_sequencer: RTL and testbench



---
 rtl/top_cmd_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_top_cmd_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_cmd_sequencer.sv
// Command front end: queues host write/read/ALU commands, issues them one at a
// time as single-cycle strobes, waits for done and queues read data back.
module top_cmd_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH_EXT = 20,
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_type,
    input  logic [ADDR_WIDTH_EXT-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_data,
    input  logic [3:0]                cmd_alu_op,
    input  logic                      cmd_alu_ext,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      we,
    output logic                      re,
    output logic                      alu_start,
    output logic [3:0]                alu_op,
    output logic                      alu_to_external,
    output logic [ADDR_WIDTH_EXT-1:0] addr,
    output logic [DATA_WIDTH-1:0]     data_in,
    input  logic [DATA_WIDTH-1:0]     data_out,
    input  logic                      busy,
    input  logic                      done,
    output logic                      idle,
    output logic                      err_illegal,
    output logic                      err_timeout
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int RCW = RPW + 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_M1 = TIMEOUT_CYCLES - 1;
    localparam logic [TCW-1:0] TO_LAST = TO_M1[TCW-1:0];
    localparam logic [CCW-1:0] CMD_FULL = CMD_DEPTH[CCW-1:0];
    localparam logic [RCW-1:0] RSP_FULL = RSP_DEPTH[RCW-1:0];

    localparam logic [1:0] T_WR  = 2'b00;
    localparam logic [1:0] T_RD  = 2'b01;
    localparam logic [1:0] T_ALU = 2'b10;
    localparam logic [1:0] T_ILL = 2'b11;

    typedef struct packed {
        logic [1:0]                typ;
        logic [ADDR_WIDTH_EXT-1:0] addr;
        logic [DATA_WIDTH-1:0]     data;
        logic [3:0]                op;
        logic                      ext;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    cmd_t                  cmd_mem [CMD_DEPTH];
    cmd_t                  cmd_in;
    cmd_t                  cmd_head;
    logic [CPW-1:0]        cmd_wr_q, cmd_rd_q;
    logic [CCW-1:0]        cmd_cnt_q;
    logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
    logic [RPW-1:0]        rsp_wr_q, rsp_rd_q;
    logic [RCW-1:0]        rsp_cnt_q;

    logic cmd_empty, cmd_push, cmd_pop;
    logic rsp_full, rsp_push, rsp_pop;

    state_t                    state_q;
    logic [1:0]                typ_q;
    logic [ADDR_WIDTH_EXT-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [3:0]                op_q;
    logic                      ext_q;
    logic                      we_q, re_q, alu_q;
    logic                      err_ill_q, err_tmo_q;
    logic [TCW-1:0]            tmo_q;

    assign cmd_in    = {cmd_type, cmd_addr, cmd_data, cmd_alu_op, cmd_alu_ext};
    assign cmd_head  = cmd_mem[cmd_rd_q];
    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_ready = (cmd_cnt_q != CMD_FULL);
    assign cmd_push  = cmd_valid && cmd_ready;

    // A read is only admitted with response space, so rsp_push never overflows
    assign cmd_pop = (state_q == S_IDLE) && !cmd_empty && !busy &&
                     ((cmd_head.typ != T_RD) || !rsp_full);

    assign rsp_full  = (rsp_cnt_q == RSP_FULL);
    assign rsp_valid = (rsp_cnt_q != '0);
    assign rsp_data  = rsp_mem[rsp_rd_q];
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_push  = (state_q == S_WAIT) && done && (typ_q == T_RD);

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr_q] <= cmd_in;
        if (rsp_push) rsp_mem[rsp_wr_q] <= data_out;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_wr_q  <= '0;
            cmd_rd_q  <= '0;
            cmd_cnt_q <= '0;
            rsp_wr_q  <= '0;
            rsp_rd_q  <= '0;
            rsp_cnt_q <= '0;
        end else begin
            if (cmd_push) cmd_wr_q <= cmd_wr_q + CPW'(1);
            if (cmd_pop)  cmd_rd_q <= cmd_rd_q + CPW'(1);
            if (cmd_push && !cmd_pop) cmd_cnt_q <= cmd_cnt_q + CCW'(1);
            if (!cmd_push && cmd_pop) cmd_cnt_q <= cmd_cnt_q - CCW'(1);
            if (rsp_push) rsp_wr_q <= rsp_wr_q + RPW'(1);
            if (rsp_pop)  rsp_rd_q <= rsp_rd_q + RPW'(1);
            if (rsp_push && !rsp_pop) rsp_cnt_q <= rsp_cnt_q + RCW'(1);
            if (!rsp_push && rsp_pop) rsp_cnt_q <= rsp_cnt_q - RCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            typ_q     <= T_WR;
            addr_q    <= '0;
            data_q    <= '0;
            op_q      <= '0;
            ext_q     <= 1'b0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            alu_q     <= 1'b0;
            err_ill_q <= 1'b0;
            err_tmo_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            we_q  <= 1'b0;
            re_q  <= 1'b0;
            alu_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_pop) begin
                        if (cmd_head.typ == T_ILL) begin
                            err_ill_q <= 1'b1;
                        end else begin
                            typ_q   <= cmd_head.typ;
                            addr_q  <= cmd_head.addr;
                            data_q  <= cmd_head.data;
                            op_q    <= cmd_head.op;
                            ext_q   <= cmd_head.ext;
                            we_q    <= (cmd_head.typ == T_WR);
                            re_q    <= (cmd_head.typ == T_RD);
                            alu_q   <= (cmd_head.typ == T_ALU);
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TCW'(1);
                        if (tmo_q == TO_LAST) begin
                            err_tmo_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign we              = we_q;
    assign re              = re_q;
    assign alu_start       = alu_q;
    assign alu_op          = op_q;
    assign alu_to_external = ext_q;
    assign addr            = addr_q;
    assign data_in         = data_q;
    assign idle            = (state_q == S_IDLE) && cmd_empty;
    assign err_illegal     = err_ill_q;
    assign err_timeout     = err_tmo_q;

endmodule

// File: tb/tb_top_cmd_sequencer.sv
// Directed bench for top_cmd_sequencer; the bench itself plays the subsystem
// (RAM, ALU, programmable done latency).
module tb_top_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'b00;
    logic [19:0] cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic [3:0]  cmd_alu_op = '0;
    logic        cmd_alu_ext = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic        we, re, alu_start;
    logic [3:0]  alu_op;
    logic        alu_to_external;
    logic [19:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out = '0;
    logic        busy = 1'b0;
    logic        done = 1'b0;
    logic        idle, err_illegal, err_timeout;

    top_cmd_sequencer #(
        .DATA_WIDTH(8), .ADDR_WIDTH_EXT(20), .CMD_DEPTH(4),
        .RSP_DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .cmd_alu_op(cmd_alu_op),
        .cmd_alu_ext(cmd_alu_ext),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .we(we), .re(re), .alu_start(alu_start),
        .alu_op(alu_op), .alu_to_external(alu_to_external),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .busy(busy), .done(done), .idle(idle),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] ram  [0:1023];
    logic [7:0] xram [0:1023];
    int   resp_lat = 1;
    bit   done_en  = 1'b1;
    int   lat = 0;
    logic [9:0] pend_addr = '0;
    int   we_cnt = 0, re_cnt = 0, alu_cnt = 0;
    int   multi_cnt = 0, long_cnt = 0;
    int   done_cyc = 0, last_gap = 0;
    logic prev_we = 0, prev_re = 0, prev_alu = 0;

    // Subsystem stand-in: acts on strobes, answers with done after resp_lat
    always @(negedge clk) begin
        if (!reset) begin
            lat  = 0;
            done = 1'b0;
        end else begin
            if (done) done = 1'b0;
            if ((int'(we) + int'(re) + int'(alu_start)) > 1) multi_cnt++;
            if ((we && prev_we) || (re && prev_re) || (alu_start && prev_alu))
                long_cnt++;
            if (we || re || alu_start) begin
                last_gap  = cyc - done_cyc;
                pend_addr = addr[9:0];
                lat       = resp_lat;
                if (we) begin
                    we_cnt++;
                    ram[addr[9:0]] = data_in;
                end
                if (re) re_cnt++;
                if (alu_start) begin
                    alu_cnt++;
                    if (alu_op == 4'd0) begin
                        if (alu_to_external) xram[2] = ram[0] + ram[1];
                        else                 ram[2]  = ram[0] + ram[1];
                    end
                end
            end else if (lat > 0) begin
                lat--;
                if (lat == 0 && done_en) begin
                    done     = 1'b1;
                    data_out = ram[pend_addr];
                    done_cyc = cyc;
                end
            end
        end
        prev_we  = we;
        prev_re  = re;
        prev_alu = alu_start;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [19:0] a,
                        input logic [7:0] d, input logic [3:0] op,
                        input logic ext);
        @(negedge clk);
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        chk("push_ready", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_type    = t;
        cmd_addr    = a;
        cmd_data    = d;
        cmd_alu_op  = op;
        cmd_alu_ext = ext;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 300 && !idle; i++) @(negedge clk);
        chk("idle_wait", idle, 1);
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    int w0, r0, a0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]  = '0;
            xram[i] = '0;
        end
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_strobes", {we, re, alu_start}, 0);
        chk("rst_errs", {err_illegal, err_timeout}, 0);
        chk("rst_addr", addr, 0);
        step(2);
        reset = 1'b1;
        step(1);

        // internal write then read, with exact strobe latency
        push(2'b00, 20'h00010, 8'h55, 4'd0, 1'b0);
        chk("wr_c1_we", we, 0);
        step(1);
        chk("wr_c2_we", we, 1);
        chk("wr_c2_addr", addr, 20'h00010);
        chk("wr_c2_data", data_in, 8'h55);
        chk("wr_c2_other", {re, alu_start}, 0);
        step(1);
        chk("wr_c3_we", we, 0);
        wait_idle();
        push(2'b01, 20'h00010, 8'h00, 4'd0, 1'b0);
        wait_idle();
        chk("t1_we_cnt", we_cnt, 1);
        chk("t1_re_cnt", re_cnt, 1);
        pop_chk(8'h55);
        chk("t1_rsp_empty", rsp_valid, 0);

        // external write then read with long latency
        resp_lat = 6;
        w0 = we_cnt;
        r0 = re_cnt;
        push(2'b00, 20'h00100, 8'hAA, 4'd0, 1'b0);
        push(2'b01, 20'h00100, 8'h00, 4'd0, 1'b0);
        step(5);
        chk("t2_still_wait", idle, 0);
        chk("t2_no_rsp", rsp_valid, 0);
        chk("t2_we_once", we_cnt - w0, 1);
        chk("t2_no_re_yet", re_cnt - r0, 0);
        wait_idle();
        chk("t2_b2b_gap", last_gap, 2);
        chk("t2_re_once", re_cnt - r0, 1);
        pop_chk(8'hAA);

        // ALU internal then external destination
        resp_lat = 5;
        ram[0] = 8'h05;
        ram[1] = 8'h0A;
        a0 = alu_cnt;
        push(2'b10, 20'h0, 8'h00, 4'd0, 1'b0);
        wait_idle();
        chk("t3_alu_once", alu_cnt - a0, 1);
        chk("t3_ram2", ram[2], 8'h0F);
        ram[0] = 8'h03;
        ram[1] = 8'h04;
        push(2'b10, 20'h0, 8'h00, 4'd0, 1'b1);
        step(3);
        chk("t3_wait_busy", idle, 0);
        chk("t3_ext_in_wait", alu_to_external, 1);
        wait_idle();
        chk("t3_ext_stable", alu_to_external, 1);
        chk("t3_xram2", xram[2], 8'h07);
        chk("t3_ram2_kept", ram[2], 8'h0F);

        // queue full and response backpressure
        resp_lat = 1;
        r0 = re_cnt;
        busy = 1'b1;
        push(2'b01, 20'h00010, 8'h00, 4'd0, 1'b0);
        push(2'b01, 20'h00100, 8'h00, 4'd0, 1'b0);
        push(2'b01, 20'h00000, 8'h00, 4'd0, 1'b0);
        chk("t4_ready_at3", cmd_ready, 1);
        push(2'b01, 20'h00001, 8'h00, 4'd0, 1'b0);
        chk("t4_full", cmd_ready, 0);
        step(3);
        chk("t4_busy_holds", re_cnt - r0, 0);
        busy = 1'b0;
        push(2'b01, 20'h00002, 8'h00, 4'd0, 1'b0);
        step(40);
        chk("t4_four_reads", re_cnt - r0, 4);
        chk("t4_fifth_held", idle, 0);
        pop_chk(8'h55);
        wait_idle();
        chk("t4_fifth_read", re_cnt - r0, 5);
        pop_chk(8'hAA);
        pop_chk(8'h03);
        pop_chk(8'h04);
        pop_chk(8'h0F);
        chk("t4_drained", rsp_valid, 0);

        // illegal command between two writes
        w0 = we_cnt;
        r0 = re_cnt;
        a0 = alu_cnt;
        chk("t5_pre_illegal", err_illegal, 0);
        push(2'b00, 20'h00020, 8'h11, 4'd0, 1'b0);
        push(2'b11, 20'h00022, 8'h99, 4'd0, 1'b0);
        push(2'b00, 20'h00021, 8'h22, 4'd0, 1'b0);
        wait_idle();
        chk("t5_err_illegal", err_illegal, 1);
        chk("t5_two_we", we_cnt - w0, 2);
        chk("t5_no_other", (re_cnt - r0) + (alu_cnt - a0), 0);
        chk("t5_ram20", ram[10'h20], 8'h11);
        chk("t5_ram21", ram[10'h21], 8'h22);
        chk("t5_ram22", ram[10'h22], 8'h00);

        // timeout with done stuck low
        done_en = 1'b0;
        push(2'b00, 20'h00030, 8'h33, 4'd0, 1'b0);
        step(9);
        chk("t6_no_tmo_yet", err_timeout, 0);
        chk("t6_in_wait", idle, 0);
        step(1);
        chk("t6_err_timeout", err_timeout, 1);
        chk("t6_back_idle", idle, 1);
        push(2'b01, 20'h00010, 8'h00, 4'd0, 1'b0);
        wait_idle();
        chk("t6_no_rsp", rsp_valid, 0);

        // reset in the middle of WAIT with a queued command
        push(2'b10, 20'h00005, 8'h09, 4'd3, 1'b1);
        push(2'b00, 20'h00040, 8'h44, 4'd0, 1'b0);
        step(4);
        chk("t7_pre_idle", idle, 0);
        chk("t7_pre_ext", alu_to_external, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_strobes", {we, re, alu_start}, 0);
        chk("t7_alu_op", alu_op, 0);
        chk("t7_ext", alu_to_external, 0);
        chk("t7_addr", addr, 0);
        chk("t7_data_in", data_in, 0);
        chk("t7_errs", {err_illegal, err_timeout}, 0);
        chk("t7_idle", idle, 1);
        chk("t7_cmd_ready", cmd_ready, 1);
        chk("t7_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        done_en = 1'b1;

        // recovery: fresh write/read round trip
        w0 = we_cnt;
        push(2'b00, 20'h00040, 8'h77, 4'd0, 1'b0);
        push(2'b01, 20'h00040, 8'h00, 4'd0, 1'b0);
        wait_idle();
        chk("t7_queued_dropped", we_cnt - w0, 1);
        pop_chk(8'h77);

        chk("multi_strobe", multi_cnt, 0);
        chk("long_strobe", long_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
